muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new operation this cycle.
REQ-004 SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-005 SHALL have port operand_a, input, 32 bits: rs value, from register file data_out_1.
REQ-006 SHALL have port operand_b, input, 32 bits: rt value, from register file data_out_2.
REQ-007 SHALL have port busy, output, 1 bit: high while an iterative operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo hold a new MULT/DIV result.
REQ-009 SHALL have port hi, output, 32 bits: HI register.
REQ-010 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-011 SHALL accept start only when busy=0; start while busy=1 is ignored, with no effect on state, hi, lo or done.
REQ-012 SHALL implement states IDLE, RUN, FIX: accepted MULT/MULTU/DIV/DIVU start moves IDLE->RUN; RUN lasts exactly 32 cycles (one bit per cycle, 5-bit counter 31->0); RUN->FIX after count 0; FIX->IDLE after one cycle.
REQ-013 SHALL drive busy=1 in RUN and FIX, 0 in IDLE.
REQ-014 SHALL, for an accepted start at edge 0, write hi/lo at edge 33 and drive done=1 for exactly the cycle after edge 33, with busy=0 in that cycle; back-to-back start in that cycle is accepted.
REQ-015 SHALL latch operand_a and operand_b at the accepting edge; later operand changes have no effect.
REQ-016 SHALL compute MULT/MULTU as a 64-bit product, {hi,lo} = a*b, signed for MULT and unsigned for MULTU; signed operations iterate on magnitudes, with sign correction in FIX.
REQ-017 SHALL compute DIV/DIVU with lo=quotient and hi=remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-018 SHALL, on divide by zero (both DIV and DIVU), produce lo=32'hFFFFFFFF and hi=dividend, with normal 33-cycle latency.
REQ-019 SHALL, on DIV 32'h80000000 / 32'hFFFFFFFF, produce lo=32'h80000000 and hi=0.
REQ-020 SHALL, on accepted MTHI/MTLO, write operand_a to hi/lo respectively at the accepting edge; busy stays 0 and done is not asserted.
REQ-021 SHALL treat op 110/111 with start as a no-op: no state change.
REQ-022 SHALL hold hi/lo unchanged during RUN/FIX until the FIX-edge update.

Reset
REQ-023 SHALL, while reset_n=0, immediately force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clear the operand and accumulator registers.
REQ-024 SHALL abort any in-flight operation on reset assertion mid-RUN/FIX, with no partial result reaching hi/lo.
REQ-025 SHALL accept start on the first rising edge after reset_n deasserts.

Configuration
REQ-026 SHALL support macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU use a single-cycle combinational 64-bit multiplier, write hi/lo at the accepting edge, pulse done in the following cycle and never raise busy; DIV/DIVU are unchanged.
REQ-027 SHALL, without MULDIV_FAST_MUL_EN, have MULT/MULTU follow the iterative 33-cycle path of REQ-012..REQ-014.

Structure
REQ-028 SHALL take op encodings, state encodings and the width constant (32) from the shared package mips_pkg.
REQ-029 SHALL place the restoring shift-subtract division step (remainder/quotient registers, one bit per cycle) in sub-module iter_divider, instantiated once; the multiply and FIX logic stay in muldiv_unit.

Verification
REQ-030 SHALL verify: MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> at edge 33, hi=32'hFFFFFFFE, lo=32'h00000001, done=1 for one cycle.
REQ-031 SHALL verify: MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; with MULTU on the same operands -> hi=32'h00000006, lo=32'hFFFFFFEB.
REQ-032 SHALL verify: DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000007.
REQ-033 SHALL verify: MTHI a=32'h12345678 is issued during RUN of a DIVU 100/7 -> MTHI is ignored; final hi=2, lo=14.
REQ-034 SHALL verify: reset_n pulsed low at cycle 10 of MULT -> busy=0, hi=lo=0 immediately; no done pulse; next MULTU 5*6 gives lo=30.
REQ-035 SHALL verify, with MULDIV_FAST_MUL_EN: MULTU 3*4 -> lo=12 after one edge, done pulses next cycle, busy never high.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, op/state encodings and a magnitude helper for the
// multiply/divide unit.
package mips_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/iter_divider.sv
// iter_divider: restoring shift-subtract divider on unsigned magnitudes,
// one quotient bit per step; the quotient register doubles as dividend shifter.
module iter_divider
  import mips_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic [XLEN-1:0] d;
  logic [XLEN:0] r, diff;
  assign r = {remainder, quotient[XLEN-1]};
  // r < 2*d whenever d != 0, so bit XLEN of diff is exactly the borrow
  assign diff = r - {1'b0, d};
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quotient  <= '0;
      remainder <= '0;
      d         <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      d         <= divisor;
    end else if (step) begin
      quotient  <= {quotient[XLEN-2:0], ~diff[XLEN]};
      remainder <= diff[XLEN] ? r[XLEN-1:0] : diff[XLEN-1:0];
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS HI/LO multiply/divide unit, 33-cycle iterative MULT/DIV.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational MULT/MULTU.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  state_e state, state_nx;
  logic [4:0] cnt;
  logic [1:0] op_q;
  logic [XLEN-1:0] a_q, b_q, quo, rem, mcand, res_hi, res_lo;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN:0] sum;
  logic accept, iter_op, sgn_in, sgn, fast_mul;
  logic [2*XLEN-1:0] fast_prod;

  assign accept = start & ~busy;
  assign sgn_in = ~op[0];
  assign sgn    = ~op_q[0];
`ifdef MULDIV_FAST_MUL_EN
  assign iter_op   = op == OP_DIV || op == OP_DIVU;
  assign fast_mul  = accept && (op == OP_MULT || op == OP_MULTU);
  assign fast_prod = sgn_in ? (2*XLEN)'($signed(operand_a)) * (2*XLEN)'($signed(operand_b))
                            : (2*XLEN)'(operand_a) * (2*XLEN)'(operand_b);
`else
  assign iter_op   = ~op[2];
  assign fast_mul  = 1'b0;
  assign fast_prod = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb
    state_nx = state == S_IDLE ? ((accept && iter_op) ? S_RUN : S_IDLE) :
               state == S_RUN  ? ((cnt == 5'd0) ? S_FIX : S_RUN) : S_IDLE;

  always_comb busy = state != S_IDLE;

  // shift-add multiply: multiplier sits in acc's low half and drains out
  assign mcand = mag(a_q, sgn);
  assign sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign prod  = (sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -acc : acc;

  always_comb begin
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (op_q[1]) begin
      res_hi = b_q == '0 ? a_q : (sgn && a_q[XLEN-1]) ? -rem : rem;
      res_lo = b_q == '0 ? '1 : (sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo : quo;
    end
  end

  iter_divider u_div (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept && iter_op),
    .step      (state == S_RUN),
    .dividend  (mag(operand_a, sgn_in)),
    .divisor   (mag(operand_b, sgn_in)),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= state == S_FIX || fast_mul;
      if (accept && iter_op) begin
        op_q <= op[1:0];
        a_q  <= operand_a;
        b_q  <= operand_b;
        acc  <= {{XLEN{1'b0}}, mag(operand_b, sgn_in)};
        cnt  <= 5'd31;
      end else if (state == S_RUN) begin
        acc <= {sum, acc[XLEN-1:1]};
        cnt <= cnt - 5'd1;
      end
      if (state == S_FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (fast_mul) begin
        hi <= fast_prod[2*XLEN-1:XLEN];
        lo <= fast_prod[XLEN-1:0];
      end else if (accept && op == OP_MTHI) hi <= operand_a;
      else if (accept && op == OP_MTLO) lo <= operand_a;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors; expected HI/LO and due cycle are queued at
// issue and checked by a monitor whenever done pulses.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] op = 3'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];

  muldiv_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_hilo", {hi, lo}, {e.hi, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("busy_at_done", {63'b0, busy}, 64'd0);
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit push);
    bit fastm, iter;
    fastm = FAST && o < 3'd2;
    iter  = o < 3'd4 && !fastm;
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    if (push) exp_q.push_back('{ehi, elo, cyc + 1 + (fastm ? 0 : 33)});
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", {63'b0, busy}, {63'b0, iter});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: busy still 1 expected 0 after %0d cycles", n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    reset_n = 1'b1;
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
    wait_idle();
    issue(3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1);
    wait_idle();
    issue(3'b001, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1);
    wait_idle();
    issue(3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
    wait_idle();
    issue(3'b011, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1);
    wait_idle();
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1);
    wait_idle();
    issue(3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    wait_idle();
    issue(3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1);
    wait_idle();
    // MTHI while busy must be dropped, and operand changes must not leak in
    issue(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    repeat (3) @(negedge clock);
    start = 1'b1;
    op = 3'b100;
    operand_a = 32'h12345678;
    operand_b = 32'd99;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("mthi_ignored_hi", {32'b0, hi}, 64'd1);
    chk("hold_lo_in_run", {32'b0, lo}, 64'hFFFFFFFD);
    wait_idle();
    issue(3'b101, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0, 0);
    chk("mtlo_lo", {32'b0, lo}, 64'hCAFEF00D);
    chk("mtlo_keeps_hi", {32'b0, hi}, 64'd2);
    issue(3'b100, 32'h12345678, 32'd0, 32'd0, 32'd0, 0);
    chk("mthi_hi", {32'b0, hi}, 64'h12345678);
    issue(3'b110, 32'hDEADBEEF, 32'h1, 32'd0, 32'd0, 0);
    chk("noop_hilo", {hi, lo}, 64'h12345678_CAFEF00D);
    if (!FAST) begin
      issue(3'b000, 32'd5, 32'd7, 32'd0, 32'd0, 0);
      repeat (9) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      chk("abort_done", {63'b0, done}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      issue(3'b001, 32'd5, 32'd6, 32'd0, 32'd30, 1);
      wait_idle();
    end
    issue(3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1);
    if (FAST) chk("fast_lo_after_edge", {32'b0, lo}, 64'd12);
    wait_idle();
    repeat (3) @(negedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
